// File: rtl/clkdiv_sched.sv
// -----------------------------------------------------------------------------
// clkdiv_sched
//
// Run/stop and ratio controller for a divide-by-2^n clock divider. A
// free-running period counter produces one 50% duty divided clock (ratio
// N = 2^(sel+1)) and a single-cycle tick in the last clk cycle of each period.
// Ratio changes and stops requested while running are deferred to the period
// boundary, so clk_out never shows a runt pulse.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   start      level; begins running when idle (ignored while busy)
//   stop       level; stops at the end of the current period
//   cfg_valid  new ratio select offered
//   cfg_sel    requested ratio select (clamped to NDIV-1)
//   cfg_ready  config accepted this cycle when cfg_valid && cfg_ready
//   clk_out    divided clock, driven straight from a flop
//   tick       high in the last clk cycle of each divided period
//   cur_sel    ratio select currently in effect
//   busy       controller is not idle
// -----------------------------------------------------------------------------
module clkdiv_sched #(
   parameter int NDIV        = 4,
   parameter int SEL_W       = 2,
   parameter int DEFAULT_SEL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             cfg_valid,
   input  logic [SEL_W-1:0] cfg_sel,
   output logic             cfg_ready,
   output logic             clk_out,
   output logic             tick,
   output logic [SEL_W-1:0] cur_sel,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PEND,
      STOP_PEND
   } state_t;

   state_t            state, state_n;
   logic [NDIV-1:0]   cnt, cnt_n;
   logic [NDIV-1:0]   term_cnt;
   logic [SEL_W-1:0]  sel_n;
   logic [SEL_W-1:0]  pend_sel, pend_sel_n;
   logic              pend_valid, pend_valid_n;
   logic              clk_out_n;
   logic              at_term;
   logic              cfg_fire;
   logic [SEL_W-1:0]  cfg_sel_c;

   // Terminal count N-1 for the active ratio: the low (cur_sel+1) bits set.
   always_comb begin
      term_cnt = '0;
      for (int i = 0; i < NDIV; i++) begin
         term_cnt[i] = (i <= int'(cur_sel));
      end
   end

   assign at_term   = (cnt == term_cnt);
   assign cfg_sel_c = (int'(cfg_sel) >= NDIV) ? SEL_W'(NDIV - 1) : cfg_sel;
   assign cfg_ready = (state == IDLE) || (state == RUN);
   assign cfg_fire  = cfg_valid && cfg_ready;
   assign tick      = (state != IDLE) && at_term;
   assign busy      = (state != IDLE);

   // NOTE: every signal assigned here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_n      = state;
      cnt_n        = at_term ? '0 : cnt + NDIV'(1);
      sel_n        = cur_sel;
      pend_sel_n   = pend_sel;
      pend_valid_n = pend_valid;

      case (state)
         IDLE: begin
            cnt_n = '0;
            // No period is in flight, so a new ratio applies immediately.
            if (cfg_fire) sel_n = cfg_sel_c;
            if (start && !stop) state_n = RUN;
         end
         RUN: begin
            if (cfg_fire && (cfg_sel_c != cur_sel)) begin
               pend_sel_n   = cfg_sel_c;
               pend_valid_n = 1'b1;
               state_n      = PEND;
            end
            // Stop outranks a ratio change; the change stays latched.
            if (stop) state_n = STOP_PEND;
         end
         PEND: begin
            if (at_term) begin
               sel_n        = pend_sel;
               pend_valid_n = 1'b0;
               cnt_n        = '0;
               state_n      = stop ? STOP_PEND : RUN;
            end else if (stop) begin
               state_n = STOP_PEND;
            end
         end
         STOP_PEND: begin
            if (at_term) begin
               if (pend_valid) sel_n = pend_sel;
               pend_valid_n = 1'b0;
               cnt_n        = '0;
               state_n      = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // clk_out is registered from the next count so it lines up with cnt:
   // low while cnt < N/2, high for the upper half of the period.
   assign clk_out_n = (state_n != IDLE) && cnt_n[sel_n];

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         cur_sel    <= SEL_W'(DEFAULT_SEL);
         pend_sel   <= '0;
         pend_valid <= 1'b0;
         clk_out    <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         cur_sel    <= sel_n;
         pend_sel   <= pend_sel_n;
         pend_valid <= pend_valid_n;
         clk_out    <= clk_out_n;
      end
   end

endmodule

// File: tb/tb_clkdiv_sched.sv
// -----------------------------------------------------------------------------
// tb_clkdiv_sched
//
// Directed bench for clkdiv_sched. Inputs are driven right after a rising
// edge plus 1 time unit; outputs are observed at the same point, i.e. the
// values produced by the previous edge.
// -----------------------------------------------------------------------------
module tb_clkdiv_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       stop;
   logic       cfg_valid;
   logic [1:0] cfg_sel;
   logic       cfg_ready;
   logic       clk_out;
   logic       tick;
   logic [1:0] cur_sel;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;

   clkdiv_sched #(
      .NDIV(4),
      .SEL_W(2),
      .DEFAULT_SEL(0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .stop(stop),
      .cfg_valid(cfg_valid),
      .cfg_sel(cfg_sel),
      .cfg_ready(cfg_ready),
      .clk_out(clk_out),
      .tick(tick),
      .cur_sel(cur_sel),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Check all outputs at once against hand-computed values.
   task automatic expect_out(input string tag, input logic e_clk, input logic e_tick,
                             input logic e_busy, input logic e_rdy, input logic [1:0] e_sel);
      check({tag, ".clk_out"}, 32'(clk_out), 32'(e_clk));
      check({tag, ".tick"}, 32'(tick), 32'(e_tick));
      check({tag, ".busy"}, 32'(busy), 32'(e_busy));
      check({tag, ".cfg_ready"}, 32'(cfg_ready), 32'(e_rdy));
      check({tag, ".cur_sel"}, 32'(cur_sel), 32'(e_sel));
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_sel = 2'd0;
      cyc(); cyc();
      rst = 1'b0;
      expect_out("reset", 0, 0, 0, 1, 2'd0);

      // div2 from reset: clk_out 0,1,0,1 with tick on the high cycle.
      start = 1'b1; cyc(); start = 1'b0;
      expect_out("d2_c0", 0, 0, 1, 1, 2'd0);
      for (int i = 1; i <= 4; i++) begin
         cyc();
         expect_out($sformatf("d2_c%0d", i), i[0], i[0], 1, 1, 2'd0);
      end
      // Same-ratio config and start while busy are both no-ops.
      cfg_valid = 1'b1; cfg_sel = 2'd0; start = 1'b1; cyc();
      cfg_valid = 1'b0; start = 1'b0;
      expect_out("d2_same_cfg", 1, 1, 1, 1, 2'd0);
      cyc();
      expect_out("d2_c0b", 0, 0, 1, 1, 2'd0);
      // Stop at cnt=0: finish the period (cnt=1, tick), then idle.
      stop = 1'b1; cyc(); stop = 1'b0;
      expect_out("d2_stop_pend", 1, 1, 1, 0, 2'd0);
      cyc();
      expect_out("d2_idle", 0, 0, 0, 1, 2'd0);

      // Idle config to div16 applies at once.
      cfg_valid = 1'b1; cfg_sel = 2'd3; cyc(); cfg_valid = 1'b0;
      expect_out("idle_cfg3", 0, 0, 0, 1, 2'd3);
      start = 1'b1; cyc(); start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         expect_out($sformatf("d16_c%0d", i), i >= 8, i == 15, 1, 1, 2'd3);
         cyc();
      end
      expect_out("d16_wrap", 0, 0, 1, 1, 2'd3);
      for (int i = 1; i <= 9; i++) cyc();
      expect_out("d16_c9", 1, 0, 1, 1, 2'd3);
      // Mid-period reset.
      rst = 1'b1; cyc(); rst = 1'b0;
      expect_out("mid_rst", 0, 0, 0, 1, 2'd0);

      // Restart at div4, change to div8 offered at cnt=1.
      cfg_valid = 1'b1; cfg_sel = 2'd1; cyc(); cfg_valid = 1'b0;
      expect_out("idle_cfg1", 0, 0, 0, 1, 2'd1);
      start = 1'b1; cyc(); start = 1'b0;
      expect_out("d4_c0", 0, 0, 1, 1, 2'd1);
      cyc();
      expect_out("d4_c1", 0, 0, 1, 1, 2'd1);
      cfg_valid = 1'b1; cfg_sel = 2'd2; cyc(); cfg_valid = 1'b0;
      expect_out("d4_pend_c2", 1, 0, 1, 0, 2'd1);
      cyc();
      expect_out("d4_pend_c3", 1, 1, 1, 0, 2'd1);
      cyc();
      expect_out("d8_c0", 0, 0, 1, 1, 2'd2);
      cyc();
      expect_out("d8_c1", 0, 0, 1, 1, 2'd2);
      cyc();
      expect_out("d8_c2", 0, 0, 1, 1, 2'd2);
      // Stop at cnt=2: the high half still completes.
      stop = 1'b1; cyc(); stop = 1'b0;
      expect_out("d8_sp_c3", 0, 0, 1, 0, 2'd2);
      for (int i = 4; i <= 7; i++) begin
         cyc();
         expect_out($sformatf("d8_sp_c%0d", i), 1, i == 7, 1, 0, 2'd2);
      end
      cyc();
      expect_out("d8_idle", 0, 0, 0, 1, 2'd2);

      // start+stop together in idle: stop wins.
      start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
      expect_out("start_stop_idle", 0, 0, 0, 1, 2'd2);

      // div2 with stop and a ratio change in the same (tick) cycle.
      cfg_valid = 1'b1; cfg_sel = 2'd0; cyc(); cfg_valid = 1'b0;
      start = 1'b1; cyc(); start = 1'b0;
      expect_out("d2b_c0", 0, 0, 1, 1, 2'd0);
      cyc();
      expect_out("d2b_c1", 1, 1, 1, 1, 2'd0);
      stop = 1'b1; cfg_valid = 1'b1; cfg_sel = 2'd1; cyc();
      stop = 1'b0; cfg_valid = 1'b0;
      expect_out("d2b_sp_c0", 0, 0, 1, 0, 2'd0);
      cyc();
      expect_out("d2b_sp_c1", 1, 1, 1, 0, 2'd0);
      cyc();
      expect_out("d2b_idle", 0, 0, 0, 1, 2'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
